// File: rtl/tile_query_arbiter.sv
// tile_query_arbiter: round-robin sharing of one synchronous tile-map read
// port between collision resolvers. Each grant turns a pixel coordinate into
// a map address, and the blockType comes back exactly two cycles later.
// Out-of-bounds coordinates skip the map and return OOB_TYPE.
module tile_query_arbiter #(
  parameter int          N_REQ      = 2,
  parameter int          TILE_SHIFT = 5,
  parameter int          MAP_W      = 20,
  parameter int          MAP_H      = 15,
  parameter int          ADDR_W     = 9,
  parameter logic [2:0]  OOB_TYPE   = 3'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [10*N_REQ-1:0]   req_x,
  input  logic [10*N_REQ-1:0]   req_y,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [2:0]            rsp_type,
  output logic                  map_rd_en,
  output logic [ADDR_W-1:0]     map_addr,
  input  logic [2:0]            map_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Round-robin pointer: index of the most recently granted requester.
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

  // Stage A: owner/oob alongside the registered map request.
  logic [N_REQ-1:0]  a_owner_q, a_owner_d;
  logic              a_oob_q, a_oob_d;
  logic              map_rd_en_q, map_rd_en_d;
  logic [ADDR_W-1:0] map_addr_q, map_addr_d;

  // Stage B: aligned with map_data returning from the map.
  logic [N_REQ-1:0]  b_owner_q, b_owner_d;
  logic              b_oob_q, b_oob_d;

  logic [N_REQ-1:0]  gnt_d;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [9:0]        sel_x, sel_y;
  logic [9:0]        tile_x, tile_y;
  logic              oob;
  logic [19:0]       addr_full;

  // Arbitration: first requester after rr_ptr_q, wrapping to the lowest index.
  always_comb begin
    logic [PTR_W-1:0] first_any;
    logic [PTR_W-1:0] first_after;
    logic             found_any;
    logic             found_after;
    first_any   = '0;
    first_after = '0;
    found_any   = 1'b0;
    found_after = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        first_any = PTR_W'(i);
        found_any = 1'b1;
        if (PTR_W'(i) > rr_ptr_q) begin
          first_after = PTR_W'(i);
          found_after = 1'b1;
        end
      end
    end
    gnt_idx = found_after ? first_after : first_any;
    gnt_any = found_any && !rst;
    gnt_d   = '0;
    if (gnt_any) begin
      gnt_d[gnt_idx] = 1'b1;
    end
  end

  assign gnt = gnt_d;

  // Coordinate mux and tile address computation for the granted requester.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_d[i]) begin
        sel_x = req_x[10*i +: 10];
        sel_y = req_y[10*i +: 10];
      end
    end
    tile_x    = sel_x >> TILE_SHIFT;
    tile_y    = sel_y >> TILE_SHIFT;
    oob       = (tile_x >= 10'(MAP_W)) || (tile_y >= 10'(MAP_H));
    addr_full = 20'(tile_y) * 20'(MAP_W) + 20'(tile_x);
  end

  // Next-state for pointer and both pipeline stages.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    a_owner_d   = gnt_d;
    a_oob_d     = gnt_any && oob;
    map_rd_en_d = gnt_any && !oob;
    map_addr_d  = '0;
    b_owner_d   = a_owner_q;
    b_oob_d     = a_oob_q;
    if (gnt_any) begin
      rr_ptr_d = gnt_idx;
      if (!oob) begin
        map_addr_d = addr_full[ADDR_W-1:0];
      end
    end
  end

  // State registers; reset flushes every in-flight query.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= PTR_W'(N_REQ - 1);
      a_owner_q   <= '0;
      a_oob_q     <= 1'b0;
      map_rd_en_q <= 1'b0;
      map_addr_q  <= '0;
      b_owner_q   <= '0;
      b_oob_q     <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      a_owner_q   <= a_owner_d;
      a_oob_q     <= a_oob_d;
      map_rd_en_q <= map_rd_en_d;
      map_addr_q  <= map_addr_d;
      b_owner_q   <= b_owner_d;
      b_oob_q     <= b_oob_d;
    end
  end

  assign map_rd_en = map_rd_en_q;
  assign map_addr  = map_addr_q;
  assign rsp_valid = b_owner_q;

  // Response mux: substitute OOB_TYPE for skipped reads, zero when idle.
  always_comb begin
    rsp_type = 3'd0;
    if (|b_owner_q) begin
      rsp_type = b_oob_q ? OOB_TYPE : map_data;
    end
  end

endmodule

// File: tb/tb_tile_query_arbiter.sv
// Directed bench for tile_query_arbiter: a vector table of single queries
// plus hand-written contention, mid-flight reset and idle sequences.
module tb_tile_query_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [19:0] req_x;
  logic [19:0] req_y;
  logic [1:0]  gnt;
  logic [1:0]  rsp_valid;
  logic [2:0]  rsp_type;
  logic        map_rd_en;
  logic [8:0]  map_addr;
  logic [2:0]  map_data;

  int tests;
  int fails;

  tile_query_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_type  (rsp_type),
    .map_rd_en (map_rd_en),
    .map_addr  (map_addr),
    .map_data  (map_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] md;
    logic [1:0] e_gnt;
    logic       e_rd;
    logic [8:0] e_addr;
    logic [1:0] e_rv;
    logic [2:0] e_rt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Move from the drive point to the middle of the cycle (sample point).
  task automatic mid();
    #4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    req      = 2'b00;
    req_x    = '0;
    req_y    = '0;
    map_data = 3'd0;

    //            req    x     y    md   gnt   rd   addr  rv     rt
    vecs[0] = '{2'b01, 10'd100, 10'd70,   3'd2, 2'b01, 1'b1, 9'd43,  2'b01, 3'd2};
    vecs[1] = '{2'b10, 10'd650, 10'd10,   3'd5, 2'b10, 1'b0, 9'd0,   2'b10, 3'd1};
    vecs[2] = '{2'b10, 10'd100, 10'd1003, 3'd6, 2'b10, 1'b0, 9'd0,   2'b10, 3'd1};
    vecs[3] = '{2'b01, 10'd639, 10'd479,  3'd6, 2'b01, 1'b1, 9'd299, 2'b01, 3'd6};
    vecs[4] = '{2'b01, 10'd640, 10'd0,    3'd7, 2'b01, 1'b0, 9'd0,   2'b01, 3'd1};
    vecs[5] = '{2'b10, 10'd0,   10'd0,    3'd0, 2'b10, 1'b1, 9'd0,   2'b10, 3'd0};
    vecs[6] = '{2'b10, 10'd31,  10'd32,   3'd3, 2'b10, 1'b1, 9'd20,  2'b10, 3'd3};

    // Reset state, sampled while rst is held with requests pending.
    req   = 2'b11;
    req_x = {10'd320, 10'd320};
    req_y = {10'd320, 10'd320};
    next_cycle();
    mid();
    chk("reset_gnt", 32'(gnt), 32'(2'b00));
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(2'b00));
    chk("reset_rsp_type", 32'(rsp_type), 32'(3'd0));
    chk("reset_rd_en", 32'(map_rd_en), 32'(1'b0));
    chk("reset_addr", 32'(map_addr), 32'(9'd0));
    req = 2'b00;
    do_reset();

    // Table of isolated single queries through the whole pipeline.
    for (int v = 0; v < 7; v++) begin
      req = vecs[v].req;
      // The unrequested slot carries an in-bounds decoy (tile 10,10).
      if (vecs[v].req[0]) begin
        req_x = {10'd320, vecs[v].x};
        req_y = {10'd320, vecs[v].y};
      end else begin
        req_x = {vecs[v].x, 10'd320};
        req_y = {vecs[v].y, 10'd320};
      end
      map_data = 3'd0;
      mid();
      chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vecs[v].e_gnt));
      next_cycle();
      req      = 2'b00;
      map_data = vecs[v].md;
      mid();
      chk($sformatf("vec%0d_rd_en", v), 32'(map_rd_en), 32'(vecs[v].e_rd));
      chk($sformatf("vec%0d_addr", v), 32'(map_addr), 32'(vecs[v].e_addr));
      chk($sformatf("vec%0d_early_rv", v), 32'(rsp_valid), 32'(2'b00));
      next_cycle();
      mid();
      chk($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'(vecs[v].e_rv));
      chk($sformatf("vec%0d_rsp_type", v), 32'(rsp_type), 32'(vecs[v].e_rt));
      chk($sformatf("vec%0d_rd_en_drop", v), 32'(map_rd_en), 32'(1'b0));
      next_cycle();
      $display("[TB] vector %0d req=%b x=%0d y=%0d done", v, vecs[v].req, vecs[v].x, vecs[v].y);
    end

    // Contention from reset: requester 0 at addr 43 (data 2), requester 1 OOB.
    rst      = 1'b1;
    req      = 2'b11;
    req_x    = {10'd650, 10'd100};
    req_y    = {10'd10, 10'd70};
    map_data = 3'd2;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    begin
      logic [1:0] exp_g [4];
      logic [2:0] exp_t [4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      exp_t[0] = 3'd2;  exp_t[1] = 3'd1;  exp_t[2] = 3'd2;  exp_t[3] = 3'd1;
      for (int c = 0; c < 7; c++) begin
        req = (c < 4) ? 2'b11 : 2'b00;
        mid();
        chk($sformatf("cont%0d_gnt", c), 32'(gnt), (c < 4) ? 32'(exp_g[c]) : 32'(2'b00));
        if (c >= 2 && c < 6) begin
          chk($sformatf("cont%0d_rsp_valid", c), 32'(rsp_valid), 32'(exp_g[c-2]));
          chk($sformatf("cont%0d_rsp_type", c), 32'(rsp_type), 32'(exp_t[c-2]));
        end else begin
          chk($sformatf("cont%0d_rsp_valid", c), 32'(rsp_valid), 32'(2'b00));
        end
        if (c == 1 || c == 3) begin
          chk($sformatf("cont%0d_addr", c), 32'(map_addr), 32'(9'd43));
          chk($sformatf("cont%0d_rd_en", c), 32'(map_rd_en), 32'(1'b1));
        end
        $display("[TB] contention cycle %0d gnt=%b rsp_valid=%b rsp_type=%0d", c, gnt, rsp_valid, rsp_type);
        next_cycle();
      end
    end

    // Mid-flight reset: grant requester 0, then reset before its response.
    do_reset();
    req      = 2'b01;
    req_x    = {10'd320, 10'd100};
    req_y    = {10'd320, 10'd70};
    map_data = 3'd4;
    mid();
    chk("mrst_gnt", 32'(gnt), 32'(2'b01));
    next_cycle();
    req = 2'b00;
    rst = 1'b1;
    mid();
    chk("mrst_gnt_in_rst", 32'(gnt), 32'(2'b00));
    next_cycle();
    rst = 1'b0;
    mid();
    chk("mrst_rv_t2", 32'(rsp_valid), 32'(2'b00));
    chk("mrst_rt_t2", 32'(rsp_type), 32'(3'd0));
    chk("mrst_rd_en_t2", 32'(map_rd_en), 32'(1'b0));
    next_cycle();
    mid();
    chk("mrst_rv_t3", 32'(rsp_valid), 32'(2'b00));
    next_cycle();
    req = 2'b11;
    mid();
    chk("mrst_first_gnt", 32'(gnt), 32'(2'b01));
    $display("[TB] mid-flight reset sequence done, first gnt=%b", gnt);
    next_cycle();
    req = 2'b00;
    next_cycle();
    next_cycle();

    // Idle: pointer left at requester 0, so requester 1 must win afterwards.
    map_data = 3'd7;
    for (int c = 0; c < 10; c++) begin
      mid();
      chk($sformatf("idle%0d_gnt", c), 32'(gnt), 32'(2'b00));
      chk($sformatf("idle%0d_rd_en", c), 32'(map_rd_en), 32'(1'b0));
      chk($sformatf("idle%0d_rsp_valid", c), 32'(rsp_valid), 32'(2'b00));
      chk($sformatf("idle%0d_rsp_type", c), 32'(rsp_type), 32'(3'd0));
      next_cycle();
    end
    req = 2'b11;
    mid();
    chk("idle_after_gnt", 32'(gnt), 32'(2'b10));
    $display("[TB] idle sequence done, next gnt=%b", gnt);
    next_cycle();
    req = 2'b00;
    next_cycle();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
